// File: rtl/clk_freq_pkg.sv
// Shared defaults and a width helper for the clock divider slice.
package clk_freq_pkg;

  localparam int DEFAULT_DIV   = 100;
  localparam int DEFAULT_CNT_W = 7;

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int clog2w(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(v)) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_freq_divider_counter.sv
// Wrapping modulo-DIV counter with synchronous active-high reset.
module mod_counter
  import clk_freq_pkg::*;
#(
  parameter int DIV   = DEFAULT_DIV,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;

  // wrap_o flags that the coming edge returns the count to zero
  assign wrap_o  = (cnt_q == CNT_W'(DIV - 1));
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (wrap_o) cnt_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clk_freq_divider.sv
// Registered clock divider: clk_out low for DIV-DIV/2 edges, high for DIV/2.
// Optional one-cycle tick on each clk_out rise when CLK_FREQ_TICK_EN is defined.
module clk_freq_divider
  import clk_freq_pkg::*;
#(
  parameter int DIV   = DEFAULT_DIV,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic clk_in,
  input  logic rst,
`ifdef CLK_FREQ_TICK_EN
  output logic tick,
`endif
  output logic clk_out
);

  localparam int LOW = DIV - DIV / 2;

  logic [CNT_W-1:0] count;
  logic             wrap;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_out_q = 1'b0;
  logic             clk_out_d;

  mod_counter #(.DIV(DIV), .CNT_W(CNT_W)) u_cnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .count_o (count),
    .wrap_o  (wrap)
  );

  // Value the counter takes on this edge; clk_out is decided from it so the
  // output register lines up with the counter rather than lagging a cycle.
  always_comb begin
    cnt_d = count + 1'b1;
    if (wrap) cnt_d = '0;
    clk_out_d = !wrap && (cnt_d >= CNT_W'(LOW));
  end

  always_ff @(posedge clk_in) begin
    if (rst) clk_out_q <= 1'b0;
    else     clk_out_q <= clk_out_d;
  end

  assign clk_out = clk_out_q;

`ifdef CLK_FREQ_TICK_EN
  logic tick_q = 1'b0;
  logic tick_d;

  assign tick_d = (cnt_d == CNT_W'(LOW));

  always_ff @(posedge clk_in) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_d;
  end

  assign tick = tick_q;
`else
  // Default build: no strobe register, clk_out path identical.
`endif

endmodule

// File: tb/tb_clk_freq_divider.sv
// Directed bench for clk_freq_divider at DIV=100, 3 and 2 sharing one clock.
module tb_clk_freq_divider;
  import clk_freq_pkg::*;

  typedef struct {
    logic c100;
    logic c3;
    logic c2;
    logic tk;
    int   edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic co100, co3, co2;
  logic tk100;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pos     = 0;   // edges since reset release (or since time zero)
  int   edge_no = 0;
  int   rises, falls, ticks;
  logic prev100;
  exp_t sb[$];

  always #10 clk = ~clk;

  clk_freq_divider #(.DIV(100), .CNT_W(7)) dut100 (
    .clk_in  (clk),
    .rst     (rst),
`ifdef CLK_FREQ_TICK_EN
    .tick    (tk100),
`endif
    .clk_out (co100)
  );

  clk_freq_divider #(.DIV(3), .CNT_W(clog2w(3))) dut3 (
    .clk_in  (clk),
    .rst     (rst),
`ifdef CLK_FREQ_TICK_EN
    .tick    (),
`endif
    .clk_out (co3)
  );

  clk_freq_divider #(.DIV(2), .CNT_W(clog2w(2))) dut2 (
    .clk_in  (clk),
    .rst     (rst),
`ifdef CLK_FREQ_TICK_EN
    .tick    (),
`endif
    .clk_out (co2)
  );

`ifndef CLK_FREQ_TICK_EN
  assign tk100 = 1'b0;
`endif

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected output for a divider of d after p edges since release.
  function automatic logic phase_hi(input int p, input int d);
    return ((p % d) >= (d - d / 2));
  endfunction

  // Drive one edge: push expectations, clock, pop and compare.
  task automatic step(input logic r);
    exp_t e, g;
    rst = r;
    edge_no++;
    if (r) pos = 0;
    else   pos++;
    e.c100    = r ? 1'b0 : phase_hi(pos, 100);
    e.c3      = r ? 1'b0 : phase_hi(pos, 3);
    e.c2      = r ? 1'b0 : phase_hi(pos, 2);
    e.tk      = r ? 1'b0 : ((pos % 100) == 50);
    e.edge_no = edge_no;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk($sformatf("div100_e%0d", g.edge_no), co100, g.c100);
    chk($sformatf("div3_e%0d", g.edge_no), co3, g.c3);
    chk($sformatf("div2_e%0d", g.edge_no), co2, g.c2);
`ifdef CLK_FREQ_TICK_EN
    chk($sformatf("tick_e%0d", g.edge_no), tk100, g.tk);
    if (tk100 === 1'b1) chk($sformatf("tick_on_rise_e%0d", g.edge_no), co100 & ~prev100, 1'b1);
`endif
    if (co100 === 1'b1 && prev100 === 1'b0) rises++;
    if (co100 === 1'b0 && prev100 === 1'b1) falls++;
    if (tk100 === 1'b1) ticks++;
    prev100 = co100;
  endtask

  initial begin
    // Power-up state without any reset matches post-reset state.
    #1;
    chk("init_div100", co100, 1'b0);
    chk("init_div3", co3, 1'b0);
    chk("init_div2", co2, 1'b0);
`ifdef CLK_FREQ_TICK_EN
    chk("init_tick", tk100, 1'b0);
`endif
    prev100 = co100;
    rises = 0; falls = 0; ticks = 0;

    // Free run, never reset: rises at 50,150,250; falls at 100,200.
    for (int i = 0; i < 299; i++) step(1'b0);
    chk_int("freerun_rises", rises, 3);
    chk_int("freerun_falls", falls, 2);
`ifdef CLK_FREQ_TICK_EN
    chk_int("freerun_ticks", ticks, 3);
`endif
    step(1'b0);

    // Reset held 3 edges, then a full period.
    for (int i = 0; i < 3; i++) step(1'b1);
    rises = 0; falls = 0;
    for (int i = 0; i < 100; i++) step(1'b0);
    chk_int("post_rst_rises", rises, 1);
    chk_int("post_rst_falls", falls, 1);

    // Mid-period single-edge reset while clk_out is high.
    step(1'b1);
    for (int i = 0; i < 75; i++) step(1'b0);
    chk("hi_before_abort", co100, 1'b1);
    step(1'b1);
    chk("abort_low", co100, 1'b0);
    rises = 0;
    for (int i = 0; i < 49; i++) step(1'b0);
    chk_int("no_rise_before_50", rises, 0);
    step(1'b0);
    chk_int("rise_at_50", rises, 1);
    for (int i = 0; i < 10; i++) step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_freq_divider.md
CLK_FREQ_DIVIDER -- requirements
Module: clk_freq

Interface
- REQ-001: Parameter DIV, default 100, SHALL set the clk_in rising edges per clk_out period (100 Hz -> 1 Hz); legal range 2..2^16.
- REQ-002: Parameter CNT_W, default 7, SHALL set the counter width; it SHALL be at least ceil(log2(DIV)).
- REQ-003: clk_in  input  1  SHALL be the sole clock; all logic SHALL update on its rising edge only.
- REQ-004: rst  input  1  SHALL be the reset, synchronous and active-high.
- REQ-005: clk_out  output  1  SHALL be the divided clock, driven directly from a register with no combinational path.
- REQ-006: tick  output  1  SHALL be the one-cycle strobe, present only when CLK_FREQ_TICK_EN is defined.

Function
- REQ-007: Internal counter cnt SHALL count 0..DIV-1, advancing by 1 per clk_in rising edge and wrapping from DIV-1 to 0 on the same edge.
- REQ-008: LOW = DIV - floor(DIV/2); clk_out SHALL be registered as (cnt_next >= LOW), where cnt_next is the value cnt takes on that edge.
- REQ-009: For DIV=100, clk_out SHALL be low for 50 clk_in cycles, then high for 50, repeating (50% duty, period 100).
- REQ-010: For odd DIV, the low phase SHALL be one cycle longer than the high phase.
- REQ-011: clk_out SHALL first rise on the LOW-th clk_in rising edge after reset deasserts (edge 50 for DIV=100), then every DIV edges after that.
- REQ-012: clk_out SHALL fall on the edge where cnt wraps to 0.
- REQ-013: DIV=2 SHALL produce clk_out toggling every clk_in edge, i.e. clk_in/2.
- REQ-014: No glitches SHALL occur on clk_out; it changes at most once per clk_in cycle.
- REQ-015: clk_out SHALL feed logic enables or generated-clock constraints only; clk_freq makes no skew guarantee.

Reset
- REQ-016: With rst high on a clk_in rising edge, cnt SHALL become 0 and clk_out SHALL become 0 (and tick 0) on that edge.
- REQ-017: Reset mid-period SHALL abort the current period; counting SHALL restart from 0 on the first edge with rst low.
- REQ-018: cnt and clk_out SHALL carry declaration initial values of 0, so an unreset design starts identical to post-reset.
- REQ-019: Reset held for N edges SHALL keep clk_out at 0 for all N edges.

Configuration
- REQ-020: Macro CLK_FREQ_TICK_EN defined SHALL add output tick, high for exactly one clk_in cycle on the same edge clk_out rises.
- REQ-021: tick SHALL be 0 during and immediately after reset.
- REQ-022: With CLK_FREQ_TICK_EN undefined, the tick port and its logic SHALL be absent and clk_out behaviour SHALL be unchanged.

Structure
- REQ-023: Shared package clk_freq_pkg SHALL hold DEFAULT_DIV=100, DEFAULT_CNT_W=7, and a clog2-style width helper.
- REQ-024: A sub-module mod_counter SHALL implement the wrapping modulo-DIV counter with sync reset, exposing count and wrap.
- REQ-025: clk_freq SHALL hold only the clk_out/tick registers around mod_counter.

Verification
- REQ-026: clk_in period 20 ns, 300 rising edges, no reset asserted -> clk_out rises exactly 3 times (edges 50, 150, 250) and falls at edges 100 and 200.
- REQ-027: rst high 3 edges then low, 100 edges -> clk_out 0 through edge 49 after release, 1 from edge 50 to 99, 0 at edge 100.
- REQ-028: rst asserted for 1 edge at edge 75 (clk_out high) -> clk_out 0 on that edge; next rise 50 edges after release.
- REQ-029: DIV=3, 9 edges -> clk_out pattern 0,0,1 repeating (low 2, high 1).
- REQ-030: CLK_FREQ_TICK_EN defined, DIV=100, 300 edges -> tick high exactly 3 single cycles, coincident with clk_out rising edges.
- REQ-031: DIV=2 -> clk_out toggles every edge: 0,1,0,1 after reset.
